fifo_rd_packer: RTL and testbench

Read-side drain stage placed directly downstream of the async `fifo`, in the `rclk` domain. It pops `DSIZE`-bit entries through the FIFO's `rinc`/`rempty`/`rdata` interface and packs `RATIO` consecutive entries into one wide word. The wide word is presented on a valid/ready master stream. A flush input emits a partial word, marked with `m_keep`/`m_last`, so that trailing entries are never stranded.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_rd_packer_if.sv | 26 ++
 rtl/fifo_rd_packer.sv | 119 +++++++++++
 tb/tb_fifo_rd_packer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async fifo and its read-side packer:
// a constant-foldable clog2 and the default lane-counter width.
package fifo_pkg;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 32'sd0;
      v   = value - 32'sd1;
      while (v > 32'sd0) begin
         res = res + 32'sd1;
         v   = v >>> 32'sd1;
      end
      return res;
   endfunction

   // Default packing ratio and the matching lane-counter width.
   localparam int RATIO_DEF = 32'sd4;
   localparam int CNT_W     = (clog2(RATIO_DEF) < 32'sd1) ? 32'sd1 : clog2(RATIO_DEF);

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port, flush request and wide output stream
// seen by fifo_rd_packer. The master modport is the packer side.
interface fifo_rd_packer_if #(
   parameter int DSIZE = 8,
   parameter int RATIO = 4
);
   logic                     rempty;
   logic [DSIZE-1:0]         rdata;
   logic                     rinc;
   logic                     flush;
   logic                     m_valid;
   logic                     m_ready;
   logic [DSIZE*RATIO-1:0]   m_data;
   logic [RATIO-1:0]         m_keep;
   logic                     m_last;

   modport master (
      input  rempty, rdata, flush, m_ready,
      output rinc, m_valid, m_data, m_keep, m_last
   );

   modport slave (
      output rempty, rdata, flush, m_ready,
      input  rinc, m_valid, m_data, m_keep, m_last
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side drain for the async fifo: pops DSIZE-bit entries and packs
// RATIO of them into one wide word (lane 0 = oldest). A flush request
// pushes out a partial word tagged with m_keep/m_last.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int RATIO = 4
) (
   input  logic                    rclk,
   input  logic                    rrst,
   fifo_rd_packer_if.master        bus
);

   localparam int CW = (clog2(RATIO) < 32'sd1) ? 32'sd1 : clog2(RATIO);
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 32'sd1);

   logic [CW-1:0]            cnt_r;
   logic [DSIZE-1:0]         acc_r [RATIO];
   logic                     flush_pend_r;
   logic                     m_valid_r;
   logic [DSIZE*RATIO-1:0]   m_data_r;
   logic [RATIO-1:0]         m_keep_r;
   logic                     m_last_r;

   logic                     out_free_s;
   logic                     pop_s;
   logic                     full_s;
   logic                     flush_act_s;
   logic [CW:0]              fill_s;
   logic                     emit_s;
   logic [DSIZE*RATIO-1:0]   word_s;
   logic [RATIO-1:0]         keep_s;

   // Pop and emit decisions; rdata only feeds the word, never rinc.
   always_comb begin
      out_free_s  = !m_valid_r || bus.m_ready;
      pop_s       = !rrst && !bus.rempty && ((cnt_r < LAST_LANE) || out_free_s);
      full_s      = pop_s && (cnt_r == LAST_LANE);
      flush_act_s = bus.flush || flush_pend_r;
      fill_s      = {1'b0, cnt_r} + {{CW{1'b0}}, pop_s};
      emit_s      = full_s || (flush_act_s && out_free_s && (fill_s != {(CW+1){1'b0}}));
   end

   // Assemble the candidate output word: filled lanes plus the entry being
   // popped this cycle; lanes beyond the fill point are forced to zero.
   always_comb begin
      word_s = '0;
      keep_s = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (i < int'(cnt_r)) begin
            word_s[i*DSIZE +: DSIZE] = acc_r[i];
            keep_s[i]                = 1'b1;
         end else if (pop_s && (i == int'(cnt_r))) begin
            word_s[i*DSIZE +: DSIZE] = bus.rdata;
            keep_s[i]                = 1'b1;
         end else begin
            word_s[i*DSIZE +: DSIZE] = {DSIZE{1'b0}};
            keep_s[i]                = 1'b0;
         end
      end
   end

   // Accumulator lanes and lane counter.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         cnt_r <= {CW{1'b0}};
         for (int i = 0; i < RATIO; i++) begin
            acc_r[i] <= {DSIZE{1'b0}};
         end
      end else begin
         if (pop_s) begin
            acc_r[cnt_r] <= bus.rdata;
         end
         if (emit_s) begin
            cnt_r <= {CW{1'b0}};
         end else if (pop_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Pending flush: held until a word goes out or there is nothing to flush.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         flush_pend_r <= 1'b0;
      end else if (emit_s) begin
         flush_pend_r <= 1'b0;
      end else if (flush_act_s && (fill_s == {(CW+1){1'b0}})) begin
         flush_pend_r <= 1'b0;
      end else begin
         flush_pend_r <= flush_act_s;
      end
   end

   // Output register: load on emit, hold under backpressure, drop on handshake.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         m_valid_r <= 1'b0;
         m_data_r  <= '0;
         m_keep_r  <= '0;
         m_last_r  <= 1'b0;
      end else if (emit_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= word_s;
         m_keep_r  <= keep_s;
         m_last_r  <= flush_act_s;
      end else if (bus.m_ready) begin
         m_valid_r <= 1'b0;
      end
   end

   assign bus.rinc    = pop_s;
   assign bus.m_valid = m_valid_r;
   assign bus.m_data  = m_data_r;
   assign bus.m_keep  = m_keep_r;
   assign bus.m_last  = m_last_r;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DSIZE=8, RATIO=4). A queue models
// the show-ahead FIFO; expected output words go into a scoreboard queue and
// are compared whenever the DUT completes a handshake.
module tb_fifo_rd_packer;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   typedef struct {
      logic flush;
      logic m_ready;
      logic exp_rinc;
      logic exp_valid;
   } vec_t;

   logic clk;
   logic rrst;

   fifo_rd_packer_if #(.DSIZE(8), .RATIO(4)) bif ();

   fifo_rd_packer #(.DSIZE(8), .RATIO(4)) dut (
      .rclk (clk),
      .rrst (rrst),
      .bus  (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] fq [$];
   word_t      exp_q [$];
   int         total;
   int         bad;
   int         pops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.data = d;
      w.keep = k;
      w.last = l;
      exp_q.push_back(w);
   endtask

   // One clock: present FIFO head, score any handshake, advance the edge.
   task automatic cycle();
      logic  pop;
      word_t w;
      bif.rempty = (fq.size() == 0);
      bif.rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
      #1;
      pop = bif.rinc;
      if (bif.m_valid && bif.m_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got 0x%0h expected none", bif.m_data);
         end else begin
            w = exp_q.pop_front();
            chk("word_data", bif.m_data, w.data);
            chk("word_keep", {28'h0, bif.m_keep}, {28'h0, w.keep});
            chk("word_last", {31'h0, bif.m_last}, {31'h0, w.last});
         end
      end
      @(posedge clk);
      #1;
      if (pop) begin
         void'(fq.pop_front());
         pops++;
      end
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() != 0) cycle();
      end
      chk(name, exp_q.size(), 32'd0);
   endtask

   vec_t vecs [8];

   initial begin
      total = 0;
      bad   = 0;
      pops  = 0;
      rrst  = 1'b1;
      bif.rempty = 1'b1;
      bif.rdata  = 8'h00;
      bif.flush  = 1'b0;
      bif.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vecs[i].flush     = i[0];
         vecs[i].m_ready   = 1'($urandom_range(0, 1));
         vecs[i].exp_rinc  = 1'b0;
         vecs[i].exp_valid = 1'b0;
      end

      // Reset state, with data waiting in the FIFO.
      @(posedge clk);
      #1;
      fq.push_back(8'h55);
      bif.rempty = 1'b0;
      bif.rdata  = 8'h55;
      #1;
      chk("reset_rinc", {31'h0, bif.rinc}, 32'd0);
      cycle();
      chk("reset_valid", {31'h0, bif.m_valid}, 32'd0);
      chk("reset_data", bif.m_data, 32'd0);
      chk("reset_keep", {28'h0, bif.m_keep}, 32'd0);
      chk("reset_last", {31'h0, bif.m_last}, 32'd0);
      fq.delete();
      rrst = 1'b0;
      cycle();

      // Streaming: 8 entries, rinc high for 8 straight cycles.
      for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
      push_exp(32'h04030201, 4'hF, 1'b0);
      push_exp(32'h08070605, 4'hF, 1'b0);
      pops = 0;
      for (int i = 0; i < 8; i++) cycle();
      chk("stream_pops", pops, 32'd8);
      drain("stream_drain", 10);

      // Backpressure: 12 entries, only 7 popped while m_ready is low.
      bif.m_ready = 1'b0;
      for (int i = 0; i < 12; i++) fq.push_back(8'(8'h10 + 8'(i)));
      push_exp(32'h13121110, 4'hF, 1'b0);
      push_exp(32'h17161514, 4'hF, 1'b0);
      push_exp(32'h1B1A1918, 4'hF, 1'b0);
      pops = 0;
      for (int i = 0; i < 12; i++) cycle();
      chk("bp_pops", pops, 32'd7);
      chk("bp_rinc", {31'h0, bif.rinc}, 32'd0);
      chk("bp_valid", {31'h0, bif.m_valid}, 32'd1);
      chk("bp_hold", bif.m_data, 32'h13121110);
      bif.m_ready = 1'b1;
      drain("bp_drain", 30);
      chk("bp_fifo_empty", fq.size(), 32'd0);

      // Partial flush of 3 entries, then a flush with nothing buffered.
      fq.push_back(8'hA1);
      fq.push_back(8'hA2);
      fq.push_back(8'hA3);
      for (int i = 0; i < 3; i++) cycle();
      chk("pf_no_word", {31'h0, bif.m_valid}, 32'd0);
      push_exp(32'h00A3A2A1, 4'h7, 1'b1);
      bif.flush = 1'b1;
      cycle();
      bif.flush = 1'b0;
      drain("pf_drain", 5);
      bif.flush = 1'b1;
      cycle();
      bif.flush = 1'b0;
      chk("empty_flush_valid0", {31'h0, bif.m_valid}, 32'd0);
      cycle();
      chk("empty_flush_valid1", {31'h0, bif.m_valid}, 32'd0);

      // Flush coinciding with the pop of the second entry.
      fq.push_back(8'hB1);
      cycle();
      fq.push_back(8'hB2);
      push_exp(32'h0000B2B1, 4'h3, 1'b1);
      bif.flush = 1'b1;
      cycle();
      bif.flush = 1'b0;
      drain("fp_drain", 5);

      // Reset after two pops discards the partial word.
      for (int i = 0; i < 6; i++) fq.push_back(8'(8'hC1 + 8'(i)));
      cycle();
      cycle();
      rrst = 1'b1;
      bif.rempty = 1'b0;
      bif.rdata  = fq[0];
      #1;
      chk("rst_mid_rinc", {31'h0, bif.rinc}, 32'd0);
      cycle();
      chk("rst_mid_valid", {31'h0, bif.m_valid}, 32'd0);
      chk("rst_mid_data", bif.m_data, 32'd0);
      chk("rst_mid_keep", {28'h0, bif.m_keep}, 32'd0);
      rrst = 1'b0;
      push_exp(32'hC6C5C4C3, 4'hF, 1'b0);
      drain("rst_mid_drain", 10);

      // Empty gating, table-driven.
      for (int i = 0; i < 8; i++) begin
         bif.flush   = vecs[i].flush;
         bif.m_ready = vecs[i].m_ready;
         bif.rempty  = 1'b1;
         #1;
         chk("gate_rinc", {31'h0, bif.rinc}, {31'h0, vecs[i].exp_rinc});
         cycle();
         chk("gate_valid", {31'h0, bif.m_valid}, {31'h0, vecs[i].exp_valid});
      end
      bif.flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
